// File: rtl/seg_reg_ctrl_param.sv
// Purpose: pipeline-segment register for a control bundle with valid bit, per-bit flush masking and deferred flush.
// Latency: 1 cycle data_in/valid_in -> data_out/valid_out; all outputs registered.
// Backpressure: bubble holds the stage; a flush seen during bubble is parked (HOLD_FLUSH=1) until bubble drops.
// Optional perf counters (bubble_cnt, flush_cnt, perf_clr) are built only when SEG_REG_PERF_EN is defined.
module seg_reg_ctrl_param #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] FLUSH_MASK = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] FLUSH_VAL  = {WIDTH{1'b0}},
   parameter bit               HOLD_FLUSH = 1'b1
`ifdef SEG_REG_PERF_EN
   ,parameter int              CNT_W      = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bubble,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic             flush_pending
`ifdef SEG_REG_PERF_EN
   ,input  logic             perf_clr
   ,output logic [CNT_W-1:0] bubble_cnt
   ,output logic [CNT_W-1:0] flush_cnt
`endif
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             pend_q, pend_d;
   logic             apply_flush;

   // Next state: bubble holds (and may park a flush), then flush, then normal load.
   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      pend_d      = pend_q;
      apply_flush = 1'b0;
      if (bubble) begin
         // With HOLD_FLUSH=0 pend_q never leaves its reset value of 0.
         if (HOLD_FLUSH && flush) begin
            pend_d = 1'b1;
         end
      end else if (flush || pend_q) begin
         apply_flush = 1'b1;
         valid_d     = 1'b0;
         data_d      = (FLUSH_VAL & FLUSH_MASK) | (data_in & ~FLUSH_MASK);
         pend_d      = 1'b0;
      end else begin
         data_d  = data_in;
         valid_d = valid_in;
      end
   end

   // Stage registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         pend_q  <= pend_d;
      end
   end

   assign data_out      = data_q;
   assign valid_out     = valid_q;
   assign flush_pending = pend_q;

`ifdef SEG_REG_PERF_EN
   logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
   logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

   // Saturating counters; clear wins over increment.
   always_comb begin
      bub_cnt_d = bub_cnt_q;
      fl_cnt_d  = fl_cnt_q;
      if (perf_clr) begin
         bub_cnt_d = '0;
         fl_cnt_d  = '0;
      end else begin
         if (bubble && (bub_cnt_q != {CNT_W{1'b1}})) begin
            bub_cnt_d = bub_cnt_q + CNT_W'(1);
         end
         if (apply_flush && (fl_cnt_q != {CNT_W{1'b1}})) begin
            fl_cnt_d = fl_cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bub_cnt_q <= '0;
         fl_cnt_q  <= '0;
      end else begin
         bub_cnt_q <= bub_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
      end
   end

   assign bubble_cnt = bub_cnt_q;
   assign flush_cnt  = fl_cnt_q;
`endif

endmodule

// File: tb/tb_seg_reg_ctrl_param.sv
// Directed bench for seg_reg_ctrl_param: two instances share stimulus,
// one with HOLD_FLUSH=1 (dut) and one with HOLD_FLUSH=0 (dut_nh), both mask 16'h00FF.
// Perf counter scenario is compiled in only with SEG_REG_PERF_EN.
module tb_seg_reg_ctrl_param;

   logic        clk;
   logic        rst;
   logic        bubble;
   logic        flush;
   logic        valid_in;
   logic [15:0] data_in;
   logic        valid_out, valid_out_nh;
   logic [15:0] data_out, data_out_nh;
   logic        flush_pending, flush_pending_nh;
`ifdef SEG_REG_PERF_EN
   logic        perf_clr;
   logic [1:0]  bubble_cnt, flush_cnt;
   logic [1:0]  bubble_cnt_nh, flush_cnt_nh;
`endif

   int checks   = 0;
   int failures = 0;

   seg_reg_ctrl_param #(
      .WIDTH(16), .FLUSH_MASK(16'h00FF), .FLUSH_VAL(16'h0000), .HOLD_FLUSH(1'b1)
`ifdef SEG_REG_PERF_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk(clk), .rst(rst), .bubble(bubble), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(valid_out), .data_out(data_out), .flush_pending(flush_pending)
`ifdef SEG_REG_PERF_EN
      , .perf_clr(perf_clr), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
   );

   seg_reg_ctrl_param #(
      .WIDTH(16), .FLUSH_MASK(16'h00FF), .FLUSH_VAL(16'h0000), .HOLD_FLUSH(1'b0)
`ifdef SEG_REG_PERF_EN
      , .CNT_W(2)
`endif
   ) dut_nh (
      .clk(clk), .rst(rst), .bubble(bubble), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(valid_out_nh), .data_out(data_out_nh), .flush_pending(flush_pending_nh)
`ifdef SEG_REG_PERF_EN
      , .perf_clr(perf_clr), .bubble_cnt(bubble_cnt_nh), .flush_cnt(flush_cnt_nh)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge, then settle 1 time unit so outputs are stable to sample.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input logic f, input logic v, input logic [15:0] d);
      bubble   = b;
      flush    = f;
      valid_in = v;
      data_in  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_out, 16'h0000); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=%b", valid_out, 1'b0); end
      checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=%b", flush_pending, 1'b0); end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 16'hA5C3);
      step();
      checks++; if (data_out !== 16'hA5C3) begin failures++; $display("FAIL pass_data got=%h exp=%h", data_out, 16'hA5C3); end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=%b", valid_out, 1'b1); end
      // Reset asserted between edges must clear outputs without waiting for a clock.
      #2 rst = 1'b1;
      #1;
      checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL async_rst_data got=%h exp=%h", data_out, 16'h0000); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=%b", valid_out, 1'b0); end
      rst = 1'b0;
   endtask

   task automatic test_flush_mask();
      drive(1'b0, 1'b1, 1'b1, 16'h1234);
      step();
      checks++; if (data_out !== 16'h1200) begin failures++; $display("FAIL flush_mask_data got=%h exp=%h", data_out, 16'h1200); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_mask_valid got=%b exp=%b", valid_out, 1'b0); end
      checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL flush_mask_pending got=%b exp=%b", flush_pending, 1'b0); end
      checks++; if (data_out_nh !== 16'h1200) begin failures++; $display("FAIL flush_mask_nh_data got=%h exp=%h", data_out_nh, 16'h1200); end
   endtask

   task automatic test_bubble_hold();
      drive(1'b0, 1'b0, 1'b1, 16'h00FF);
      step();
      drive(1'b1, 1'b0, 1'b0, 16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (data_out !== 16'h00FF) begin failures++; $display("FAIL bubble_hold_data[%0d] got=%h exp=%h", i, data_out, 16'h00FF); end
         checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL bubble_hold_valid[%0d] got=%b exp=%b", i, valid_out, 1'b1); end
      end
   endtask

   task automatic test_deferred_flush();
      drive(1'b0, 1'b0, 1'b1, 16'h1111);
      step();
      drive(1'b1, 1'b1, 1'b1, 16'h2222);
      step();
      checks++; if (flush_pending !== 1'b1) begin failures++; $display("FAIL defer_pend_n got=%b exp=%b", flush_pending, 1'b1); end
      checks++; if (data_out !== 16'h1111) begin failures++; $display("FAIL defer_hold_n got=%h exp=%h", data_out, 16'h1111); end
      checks++; if (flush_pending_nh !== 1'b0) begin failures++; $display("FAIL defer_nh_pend got=%b exp=%b", flush_pending_nh, 1'b0); end
      step();
      checks++; if (flush_pending !== 1'b1) begin failures++; $display("FAIL defer_pend_n1 got=%b exp=%b", flush_pending, 1'b1); end
      checks++; if (data_out !== 16'h1111) begin failures++; $display("FAIL defer_hold_n1 got=%h exp=%h", data_out, 16'h1111); end
      drive(1'b0, 1'b0, 1'b1, 16'hBEEF);
      step();
      checks++; if (data_out !== 16'hBE00) begin failures++; $display("FAIL defer_apply_data got=%h exp=%h", data_out, 16'hBE00); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL defer_apply_valid got=%b exp=%b", valid_out, 1'b0); end
      checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL defer_apply_pend got=%b exp=%b", flush_pending, 1'b0); end
      checks++; if (data_out_nh !== 16'hBEEF) begin failures++; $display("FAIL defer_nh_data got=%h exp=%h", data_out_nh, 16'hBEEF); end
      checks++; if (valid_out_nh !== 1'b1) begin failures++; $display("FAIL defer_nh_valid got=%b exp=%b", valid_out_nh, 1'b1); end
      // The repeated flushes collapse into one: the following edge loads normally.
      step();
      checks++; if (data_out !== 16'hBEEF) begin failures++; $display("FAIL defer_once_data got=%h exp=%h", data_out, 16'hBEEF); end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL defer_once_valid got=%b exp=%b", valid_out, 1'b1); end
   endtask

   task automatic test_reset_mid_pending();
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      step();
      checks++; if (flush_pending !== 1'b1) begin failures++; $display("FAIL rstpend_setup got=%b exp=%b", flush_pending, 1'b1); end
      rst = 1'b1;
      #1;
      checks++; if (flush_pending !== 1'b0) begin failures++; $display("FAIL rstpend_async got=%b exp=%b", flush_pending, 1'b0); end
      checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rstpend_data got=%h exp=%h", data_out, 16'h0000); end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 16'h0F0F);
      step();
      checks++; if (data_out !== 16'h0F0F) begin failures++; $display("FAIL rstpend_after_data got=%h exp=%h", data_out, 16'h0F0F); end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL rstpend_after_valid got=%b exp=%b", valid_out, 1'b1); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vec_d [4];
      logic        vec_v [4];
      vec_d[0] = 16'h0001; vec_v[0] = 1'b1;
      vec_d[1] = 16'hFF00; vec_v[1] = 1'b0;
      vec_d[2] = 16'h8001; vec_v[2] = 1'b1;
      vec_d[3] = 16'h7E7E; vec_v[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, vec_v[i], vec_d[i]);
         step();
         checks++; if (data_out !== vec_d[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, data_out, vec_d[i]); end
         checks++; if (valid_out !== vec_v[i]) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, valid_out, vec_v[i]); end
      end
   endtask

`ifdef SEG_REG_PERF_EN
   task automatic test_perf();
      perf_clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      perf_clr = 1'b0;
      checks++; if (bubble_cnt !== 2'd0) begin failures++; $display("FAIL perf_clr0_bub got=%0d exp=%0d", bubble_cnt, 0); end
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 5; i++) step();
      checks++; if (bubble_cnt !== 2'd3) begin failures++; $display("FAIL perf_bub_sat got=%0d exp=%0d", bubble_cnt, 3); end
      drive(1'b0, 1'b1, 1'b1, 16'h0000);
      step();
      step();
      checks++; if (flush_cnt !== 2'd2) begin failures++; $display("FAIL perf_flush_cnt got=%0d exp=%0d", flush_cnt, 2); end
      perf_clr = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      step();
      perf_clr = 1'b0;
      checks++; if (bubble_cnt !== 2'd0) begin failures++; $display("FAIL perf_clr_bub got=%0d exp=%0d", bubble_cnt, 0); end
      checks++; if (flush_cnt !== 2'd0) begin failures++; $display("FAIL perf_clr_flush got=%0d exp=%0d", flush_cnt, 0); end
   endtask
`endif

   initial begin
`ifdef SEG_REG_PERF_EN
      perf_clr = 1'b0;
`endif
      test_reset();
      test_flush_mask();
      test_bubble_hold();
      test_deferred_flush();
      test_reset_mid_pending();
      test_back_to_back();
`ifdef SEG_REG_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
